// File: rtl/mips_muldiv.sv
// Multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
// Latency: MUL_LATENCY cycles for MULT/MULTU, WIDTH+1 cycles for DIV/DIVU, 1 cycle for MTHI/MTLO.
// Backpressure: busy_o high while an op is in flight; start_i is ignored until the unit is idle again.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-low reset
//   start_i  op valid (sampled only while idle)
//   op_i     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
//   a_i      rs operand (dividend / multiplicand / MTHI-MTLO data)
//   b_i      rt operand (divisor / multiplier)
//   flush_i  abort any in-flight op; HI/LO keep their old values
//   busy_o   high whenever the unit is not idle
//   done_o   one-cycle pulse after HI/LO were written by a completing op
//   hi_o     HI register
//   lo_o     LO register
module mips_muldiv #(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_FIX  = 2'd3;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   // opa holds the multiplicand during MUL and doubles as the dividend/quotient
   // shift register during DIV; opb holds the multiplier or the divisor.
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] rem;
   logic             mul_signed;
   logic             neg_q;
   logic             neg_r;

   // Multiplier: operands extended to 2*WIDTH so one unsigned multiply serves
   // both MULT and MULTU (two's-complement product is exact modulo 2^(2*WIDTH)).
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] product;

   always_comb begin
      ext_a   = mul_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
      ext_b   = mul_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
      product = ext_a * ext_b;
   end

   // Divider step: shift the next dividend bit into the partial remainder and
   // trial-subtract. A set MSB of the difference means a borrow (no subtract).
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_diff;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   always_comb begin
      rem_sh   = {rem, opa[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, opb};
      q_fix    = neg_q ? -opa : opa;
      r_fix    = neg_r ? -rem : rem;
   end

   // Magnitudes for signed division. -2^(WIDTH-1) maps onto itself, which is
   // the correct unsigned magnitude, so the overflow case wraps naturally.
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;

   always_comb begin
      a_neg = (op_i == OP_DIV) && a_i[WIDTH-1];
      b_neg = (op_i == OP_DIV) && b_i[WIDTH-1];
      a_abs = a_neg ? -a_i : a_i;
      b_abs = b_neg ? -b_i : b_i;
   end

   assign busy_o = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         opa        <= '0;
         opb        <= '0;
         rem        <= '0;
         mul_signed <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         done_o     <= 1'b0;
         hi_o       <= '0;
         lo_o       <= '0;
      end else begin
         done_o <= 1'b0;
         if (flush_i) begin
            // Abort wins over everything, including a result due this edge.
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_i) begin
                     case (op_i)
                        OP_MTHI: begin
                           hi_o   <= a_i;
                           done_o <= 1'b1;
                        end
                        OP_MTLO: begin
                           lo_o   <= a_i;
                           done_o <= 1'b1;
                        end
                        OP_MULT, OP_MULTU: begin
                           opa        <= a_i;
                           opb        <= b_i;
                           mul_signed <= (op_i == OP_MULT);
                           cnt        <= CNT_W'(MUL_LATENCY - 1);
                           state      <= ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                           if (b_i == '0) begin
                              // Divide by zero: architecturally undefined, leave HI/LO alone.
                              done_o <= 1'b1;
                           end else begin
                              opa   <= a_abs;
                              opb   <= b_abs;
                              rem   <= '0;
                              neg_q <= a_neg ^ b_neg;
                              neg_r <= a_neg;
                              cnt   <= CNT_W'(WIDTH - 1);
                              state <= ST_DIV;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
               ST_MUL: begin
                  if (cnt == '0) begin
                     hi_o   <= product[2*WIDTH-1:WIDTH];
                     lo_o   <= product[WIDTH-1:0];
                     done_o <= 1'b1;
                     state  <= ST_IDLE;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               ST_DIV: begin
                  rem <= rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                  opa <= {opa[WIDTH-2:0], ~rem_diff[WIDTH]};
                  if (cnt == '0) begin
                     state <= ST_FIX;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               ST_FIX: begin
                  lo_o   <= q_fix;
                  hi_o   <= r_fix;
                  done_o <= 1'b1;
                  state  <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mips_muldiv.sv
module tb_mips_muldiv;

   localparam int W       = 32;
   localparam int MUL_LAT = 2;

   logic          clk;
   logic          rst;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          flush;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int checks = 0;
   int errors = 0;

   mips_muldiv #(.WIDTH(W), .MUL_LATENCY(MUL_LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .op_i    (op),
      .a_i     (a),
      .b_i     (b),
      .flush_i (flush),
      .busy_o  (busy),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   function automatic logic [63:0] mul_res(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint      sp;
      logic [63:0] up;
      if (o == 3'd0) begin
         sp = longint'($signed(x)) * longint'($signed(y));
         return 64'(sp);
      end
      up = {32'd0, x} * {32'd0, y};
      return up;
   endfunction

   // Returns {remainder, quotient} = {HI, LO}.
   function automatic logic [63:0] div_res(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint      sq;
      longint      sr;
      logic [63:0] t1;
      logic [63:0] t2;
      if (o == 3'd2) begin
         sq = longint'($signed(x)) / longint'($signed(y));
         sr = longint'($signed(x)) % longint'($signed(y));
         t1 = 64'(sq);
         t2 = 64'(sr);
         return {t2[31:0], t1[31:0]};
      end
      return {x % y, x / y};
   endfunction

   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;
   logic [63:0]  p_res;
   int           m_rem;   // busy cycles still to go
   logic         m_done;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_hi   <= '0;
         m_lo   <= '0;
         p_res  <= '0;
         m_rem  <= 0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (flush) begin
            m_rem <= 0;
         end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_hi   <= p_res[63:32];
               m_lo   <= p_res[31:0];
               m_done <= 1'b1;
            end
         end else if (start) begin
            case (op)
               3'd0, 3'd1: begin
                  p_res <= mul_res(op, a, b);
                  m_rem <= MUL_LAT;
               end
               3'd2, 3'd3: begin
                  if (b == '0) m_done <= 1'b1;
                  else begin
                     p_res <= div_res(op, a, b);
                     m_rem <= W + 1;
                  end
               end
               3'd4: begin m_hi <= a; m_done <= 1'b1; end
               3'd5: begin m_lo <= a; m_done <= 1'b1; end
               default: ;
            endcase
         end
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (rst) begin
         chk("busy", 64'(busy), 64'(m_rem > 0));
         chk("done", 64'(done), 64'(m_done));
         chk("hi",   64'(hi),   64'(m_hi));
         chk("lo",   64'(lo),   64'(m_lo));
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int n, output logic d);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      d = done;
   endtask

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   int   n;
   logic d;

   initial begin
      rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_hi", 64'(hi), 64'h0);
      chk("reset_lo", 64'(lo), 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);

      issue(3'd0, 32'hFFFF_FFFF, 32'h2);
      wait_idle(n, d);
      chk("mult_busy_cycles", 64'(n), 64'd2);
      chk("mult_done", 64'(d), 64'd1);
      chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo), 64'hFFFF_FFFE);

      issue(3'd1, 32'hFFFF_FFFF, 32'h2);
      wait_idle(n, d);
      chk("multu_hi", 64'(hi), 64'h1);
      chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

      issue(3'd2, 32'hFFFF_FFF9, 32'h2);
      wait_idle(n, d);
      chk("div_busy_cycles", 64'(n), 64'd33);
      chk("div_done", 64'(d), 64'd1);
      chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
      chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

      issue(3'd3, 32'd100, 32'd7);
      wait_idle(n, d);
      chk("divu_lo", 64'(lo), 64'd14);
      chk("divu_hi", 64'(hi), 64'd2);

      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n, d);
      chk("divovf_lo", 64'(lo), 64'h8000_0000);
      chk("divovf_hi", 64'(hi), 64'h0);

      issue(3'd4, 32'h55, 32'h0);
      wait_idle(n, d);
      chk("mthi_done", 64'(d), 64'd1);
      issue(3'd5, 32'h55, 32'h0);
      wait_idle(n, d);
      issue(3'd3, 32'h1234, 32'h0);
      wait_idle(n, d);
      chk("divz_busy_cycles", 64'(n), 64'd0);
      chk("divz_done", 64'(d), 64'd1);
      chk("divz_hi", 64'(hi), 64'h55);
      chk("divz_lo", 64'(lo), 64'h55);

      // Flush a divide in its 10th busy cycle.
      issue(3'd2, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'h0);
      chk("flush_done", 64'(done), 64'h0);
      chk("flush_hi", 64'(hi), 64'h55);
      chk("flush_lo", 64'(lo), 64'h55);

      // MTLO together with flush: flush wins.
      start = 1'b1; op = 3'd5; a = 32'hAA; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("mtlo_flush_lo", 64'(lo), 64'h55);
      chk("mtlo_flush_done", 64'(done), 64'h0);

      // A second start while busy is dropped.
      issue(3'd0, 32'd3, 32'd5);
      start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      wait_idle(n, d);
      chk("busy_start_lo", 64'(lo), 64'd15);
      chk("busy_start_hi", 64'(hi), 64'd0);

      // Reset in the middle of a multiply.
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'h0);
      chk("rst_mid_hi", 64'(hi), 64'h0);
      chk("rst_mid_lo", 64'(lo), 64'h0);
      #1 rst = 1'b1;

      // Random traffic: starts while busy, back-to-back ops, flushes anywhere.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         op    = 3'($urandom_range(0, 7));
         a     = rnd_val();
         b     = rnd_val();
         flush = ($urandom_range(0, 29) == 0);
      end
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      wait_idle(n, d);
      chk("drain_busy", 64'(busy), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
